// File: rtl/axis_mon_axil_poller.sv
`default_nettype none
// ============================================================================
//  Module   : axis_mon_axil_poller
//  Purpose  : AXI-Lite initiator for the AXI-Stream monitor statistics block.
//             A start pulse reads a contiguous window of NUM_REGS 32-bit
//             registers one transaction at a time and streams each word out
//             on a valid/ready interface. A clear_req pulse writes 32'h1 to
//             the monitor's self-clearing clear register.
//  Ports    :
//    clk, rst_n                 - clock, asynchronous active-low reset
//    start, clear_req           - single-cycle requests (only honoured in IDLE)
//    busy, done, err            - status: not idle / completion pulse /
//                                 sticky error on a non-OKAY response
//    m_data, m_index, m_last,
//    m_valid, m_ready           - output stream of words read
//    m_axil_aw*, m_axil_w*,
//    m_axil_b*                  - AXI-Lite write channels
//    m_axil_ar*, m_axil_r*      - AXI-Lite read channels
//  Revision : 1.0 - initial release
// ============================================================================
module axis_mon_axil_poller #(
    parameter int                ADDR_W     = 7,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                NUM_REGS   = 18,
    parameter logic [ADDR_W-1:0] CLEAR_ADDR = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            start,
    input  logic                            clear_req,
    output logic                            busy,
    output logic                            done,
    output logic                            err,

    output logic [31:0]                     m_data,
    output logic [$clog2(NUM_REGS+1)-1:0]   m_index,
    output logic                            m_last,
    output logic                            m_valid,
    input  logic                            m_ready,

    output logic [ADDR_W-1:0]               m_axil_awaddr,
    output logic                            m_axil_awvalid,
    input  logic                            m_axil_awready,
    output logic [31:0]                     m_axil_wdata,
    output logic [3:0]                      m_axil_wstrb,
    output logic                            m_axil_wvalid,
    input  logic                            m_axil_wready,
    input  logic [1:0]                      m_axil_bresp,
    input  logic                            m_axil_bvalid,
    output logic                            m_axil_bready,

    output logic [ADDR_W-1:0]               m_axil_araddr,
    output logic                            m_axil_arvalid,
    input  logic                            m_axil_arready,
    input  logic [31:0]                     m_axil_rdata,
    input  logic [1:0]                      m_axil_rresp,
    input  logic                            m_axil_rvalid,
    output logic                            m_axil_rready
);

    localparam int                  c_IDX_W    = $clog2(NUM_REGS + 1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0]   c_STEP     = ADDR_W'(4);

    typedef enum logic [2:0] {
        c_ST_IDLE  = 3'd0,
        c_ST_WR    = 3'd1,
        c_ST_WRESP = 3'd2,
        c_ST_RADDR = 3'd3,
        c_ST_RDATA = 3'd4,
        c_ST_OUT   = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [31:0]          r_m_data;
    logic [c_IDX_W-1:0]   r_m_index;
    logic                 r_m_last;
    logic                 r_m_valid;
    logic [ADDR_W-1:0]    r_awaddr;
    logic                 r_awvalid;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_wvalid;
    logic                 r_bready;
    logic [ADDR_W-1:0]    r_araddr;
    logic                 r_arvalid;
    logic                 r_rready;

    // A write channel counts as finished once it has been accepted, either
    // in an earlier cycle (valid already dropped) or in this one.
    logic w_aw_fin;
    logic w_w_fin;

    assign w_aw_fin = !r_awvalid || m_axil_awready;
    assign w_w_fin  = !r_wvalid  || m_axil_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_m_data  <= 32'h0;
            r_m_index <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A clear takes priority; a simultaneous start is dropped.
                    if (clear_req) begin
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_awaddr  <= CLEAR_ADDR;
                        r_wdata   <= 32'h1;
                        r_wstrb   <= 4'hF;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= c_ST_WR;
                    end else if (start) begin
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_araddr  <= BASE_ADDR;
                        r_m_index <= '0;
                        r_arvalid <= 1'b1;
                        r_state   <= c_ST_RADDR;
                    end
                end

                c_ST_WR: begin
                    if (r_awvalid && m_axil_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axil_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= c_ST_WRESP;
                    end
                end

                c_ST_WRESP: begin
                    if (m_axil_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axil_bresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_RADDR: begin
                    if (m_axil_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_ST_RDATA;
                    end
                end

                c_ST_RDATA: begin
                    if (m_axil_rvalid) begin
                        r_rready  <= 1'b0;
                        r_m_data  <= m_axil_rdata;
                        if (m_axil_rresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_m_valid <= 1'b1;
                        r_m_last  <= (r_m_index == c_LAST_IDX);
                        r_state   <= c_ST_OUT;
                    end
                end

                c_ST_OUT: begin
                    // The next read is not issued until the current word is
                    // taken, so stream backpressure stalls the AXI side.
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (r_m_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_araddr  <= r_araddr + c_STEP;
                            r_m_index <= r_m_index + c_IDX_W'(1);
                            r_arvalid <= 1'b1;
                            r_state   <= c_ST_RADDR;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign m_data         = r_m_data;
    assign m_index        = r_m_index;
    assign m_last         = r_m_last;
    assign m_valid        = r_m_valid;
    assign m_axil_awaddr  = r_awaddr;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_araddr;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axis_mon_axil_poller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_mon_axil_poller
//  Purpose  : Self-checking bench for axis_mon_axil_poller. An AXI-Lite slave
//             model with configurable ready/response delays answers reads
//             with addr*0x01010101; scenario records list stimulus and the
//             expected completion latency and error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_mon_axil_poller;

    localparam int c_ADDR_W = 7;
    localparam int c_NUM    = 18;
    localparam int c_IDX_W  = $clog2(c_NUM + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start, clear_req;
    logic                 busy, done, err;
    logic [31:0]          m_data;
    logic [c_IDX_W-1:0]   m_index;
    logic                 m_last, m_valid, m_ready;
    logic [c_ADDR_W-1:0]  awaddr, araddr;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rvalid, rready;
    logic [31:0]          wdata, rdata;
    logic [3:0]           wstrb;
    logic [1:0]           bresp, rresp;

    always #5 clk = ~clk;

    axis_mon_axil_poller #(
        .ADDR_W     (c_ADDR_W),
        .BASE_ADDR  (7'h00),
        .NUM_REGS   (c_NUM),
        .CLEAR_ADDR (7'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .clear_req      (clear_req),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .m_data         (m_data),
        .m_index        (m_index),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_axil_awaddr  (awaddr),
        .m_axil_awvalid (awvalid),
        .m_axil_awready (awready),
        .m_axil_wdata   (wdata),
        .m_axil_wstrb   (wstrb),
        .m_axil_wvalid  (wvalid),
        .m_axil_wready  (wready),
        .m_axil_bresp   (bresp),
        .m_axil_bvalid  (bvalid),
        .m_axil_bready  (bready),
        .m_axil_araddr  (araddr),
        .m_axil_arvalid (arvalid),
        .m_axil_arready (arready),
        .m_axil_rdata   (rdata),
        .m_axil_rresp   (rresp),
        .m_axil_rvalid  (rvalid),
        .m_axil_rready  (rready)
    );

    // kind: 0 = start, 1 = clear_req, 2 = both together
    typedef struct {
        int         kind;
        int         ar_dly;
        int         aw_dly;
        int         w_dly;
        int         rlat;
        bit         bp;
        int         err_word;
        logic [1:0] bresp;
        int         exp_lat;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [31:0]        d;
        logic [c_IDX_W-1:0] i;
        logic               l;
    } beat_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // slave configuration
    int         cfg_ar_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_rlat = 2;
    bit         cfg_bp = 1'b0;
    int         cfg_err_word = -1;
    logic [1:0] cfg_bresp = 2'b00;

    // slave / monitor state
    int                  rwait, r_cnt, ar_wcnt, aw_wcnt, w_wcnt;
    bit                  r_hs_prev, b_hs_prev, aw_seen, w_seen;
    logic [c_ADDR_W-1:0] ar_q;
    logic [c_ADDR_W-1:0] ar_log[$];
    beat_t               beats[$];
    int                  aw_n, w_n, done_n, done_cyc, viol, r_err_cyc, err_rise;
    logic [c_ADDR_W-1:0] aw_addr_l;
    logic [31:0]         w_data_l;
    logic [3:0]          w_strb_l;
    bit                  err_prev, p_mstall, p_arstall;
    beat_t               p_beat;
    logic [c_ADDR_W-1:0] p_araddr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            m_ready = 1'b0;
            rwait = 0; ar_wcnt = 0; aw_wcnt = 0; w_wcnt = 0;
            r_hs_prev = 1'b0; b_hs_prev = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
            p_mstall = 1'b0; p_arstall = 1'b0; err_prev = 1'b0;
        end else begin
            // ---- slave drive for this cycle ----
            if (arvalid) begin
                if (ar_wcnt >= cfg_ar_dly) arready = 1'b1;
                else begin arready = 1'b0; ar_wcnt++; end
            end else begin
                arready = 1'b0; ar_wcnt = 0;
            end
            if (r_hs_prev) rvalid = 1'b0;
            if (rwait > 0) begin
                rwait--;
                if (rwait == 0) begin
                    rvalid = 1'b1;
                    rdata  = 32'(ar_q) * 32'h01010101;
                    rresp  = (r_cnt == cfg_err_word) ? 2'b10 : 2'b00;
                end
            end
            if (awvalid && !aw_seen) begin
                if (aw_wcnt >= cfg_aw_dly) awready = 1'b1;
                else begin awready = 1'b0; aw_wcnt++; end
            end else begin
                awready = 1'b0; aw_wcnt = 0;
            end
            if (wvalid && !w_seen) begin
                if (w_wcnt >= cfg_w_dly) wready = 1'b1;
                else begin wready = 1'b0; w_wcnt++; end
            end else begin
                wready = 1'b0; w_wcnt = 0;
            end
            if (b_hs_prev) begin
                bvalid = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
            end else if (aw_seen && w_seen) begin
                bvalid = 1'b1; bresp = cfg_bresp;
            end
            m_ready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;

            // ---- observe this cycle ----
            if (p_mstall && !(m_valid && m_data == p_beat.d && m_index == p_beat.i && m_last == p_beat.l))
                viol++;
            if (p_arstall && !(arvalid && araddr == p_araddr))
                viol++;
            p_mstall = m_valid && !m_ready;
            p_beat   = '{m_data, m_index, m_last};
            p_arstall = arvalid && !arready;
            p_araddr  = araddr;
            if (arvalid && m_valid) viol++;
            if (bready && !(aw_seen && w_seen)) viol++;

            r_hs_prev = rvalid && rready;
            b_hs_prev = bvalid && bready;
            if (arvalid && arready) begin
                ar_log.push_back(araddr); ar_q = araddr; rwait = cfg_rlat;
            end
            if (rvalid && rready) begin
                if (rresp != 2'b00) r_err_cyc = cyc;
                r_cnt++;
            end
            if (awvalid && awready) begin aw_seen = 1'b1; aw_addr_l = awaddr; aw_n++; end
            if (wvalid && wready) begin w_seen = 1'b1; w_data_l = wdata; w_strb_l = wstrb; w_n++; end
            if (m_valid && m_ready) beats.push_back('{m_data, m_index, m_last});
            if (done) begin
                done_n++; done_cyc = cyc;
                if (busy) viol++;
            end
            if (err && !err_prev) err_rise = cyc;
            err_prev = err;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        ar_log.delete(); beats.delete();
        aw_n = 0; w_n = 0; done_n = 0; done_cyc = -1; viol = 0; r_cnt = 0;
        r_err_cyc = -100; err_rise = -1;
        aw_addr_l = '0; w_data_l = '0; w_strb_l = '0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && done_n == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    function automatic int out_ones();
        return $countones({busy, done, err, m_data, m_index, m_last, m_valid,
                           awaddr, awvalid, wdata, wstrb, wvalid, bready,
                           araddr, arvalid, rready});
    endfunction

    task automatic run_vec(input vec_t v);
        int t;
        beat_t exp_b;
        @(negedge clk);
        cfg_ar_dly = v.ar_dly; cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly;
        cfg_rlat = v.rlat; cfg_bp = v.bp; cfg_err_word = v.err_word; cfg_bresp = v.bresp;
        clear_logs();
        start     = (v.kind == 0 || v.kind == 2);
        clear_req = (v.kind == 1 || v.kind == 2);
        t = cyc;
        @(negedge clk);
        start = 1'b0; clear_req = 1'b0;
        chk("busy_t1", longint'(busy), 1);
        wait_done();
        chk("done_cnt", done_n, 1);
        if (v.exp_lat >= 0) chk("done_lat", done_cyc - t, v.exp_lat);
        chk("err", longint'(err), longint'(v.exp_err));
        chk("proto_viol", viol, 0);
        if (v.kind == 0) begin
            chk("beats", beats.size(), c_NUM);
            chk("ar_cnt", ar_log.size(), c_NUM);
            chk("aw_cnt", aw_n, 0);
            for (int i = 0; i < c_NUM && i < beats.size(); i++) begin
                exp_b.d = 32'(4 * i) * 32'h01010101;
                exp_b.i = c_IDX_W'(i);
                exp_b.l = (i == c_NUM - 1);
                chk($sformatf("beat%0d", i), {beats[i].d, beats[i].i, beats[i].l},
                    {exp_b.d, exp_b.i, exp_b.l});
            end
            for (int i = 0; i < c_NUM && i < ar_log.size(); i++)
                chk($sformatf("araddr%0d", i), ar_log[i], 4 * i);
            if (v.err_word >= 0) chk("err_rise", err_rise - r_err_cyc, 1);
        end else begin
            chk("ar_cnt", ar_log.size(), 0);
            chk("aw_cnt", aw_n, 1);
            chk("w_cnt", w_n, 1);
            chk("awaddr", aw_addr_l, 0);
            chk("wdata", w_data_l, 1);
            chk("wstrb", w_strb_l, 15);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int t;
        vecs[0] = '{0, 0, 0, 0, 2, 1'b0, -1, 2'b00, 73, 1'b0};
        vecs[1] = '{1, 0, 3, 0, 2, 1'b0, -1, 2'b00,  6, 1'b0};
        vecs[2] = '{2, 0, 0, 0, 2, 1'b0, -1, 2'b00,  3, 1'b0};
        vecs[3] = '{0, 0, 0, 0, 2, 1'b1, -1, 2'b00, -1, 1'b0};
        vecs[4] = '{0, 0, 0, 0, 2, 1'b0,  5, 2'b00, 73, 1'b1};
        vecs[5] = '{1, 0, 0, 2, 2, 1'b0, -1, 2'b10,  5, 1'b1};
        vecs[6] = '{0, 2, 0, 0, 1, 1'b0, -1, 2'b00, 91, 1'b0};

        rst_n = 1'b0; start = 1'b0; clear_req = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        chk("reset_outputs", out_ones(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[k]) run_vec(vecs[k]);

        // requests while busy are ignored
        @(negedge clk);
        cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 0; cfg_rlat = 2;
        cfg_bp = 1'b0; cfg_err_word = -1; cfg_bresp = 2'b00;
        clear_logs();
        start = 1'b1; t = cyc;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; clear_req = 1'b1;
        @(negedge clk); start = 1'b0; clear_req = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        chk("busy_req_done_cnt", done_n, 1);
        chk("busy_req_lat", done_cyc - t, 73);
        chk("busy_req_aw", aw_n, 0);
        chk("busy_req_ar", ar_log.size(), c_NUM);
        chk("busy_req_idle", longint'(busy), 0);

        // reset while waiting for read data
        @(negedge clk);
        clear_logs();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
        chk("reach_rdata", longint'(rready), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", out_ones(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
